// File: rtl/if_neuron_scheduler_if.sv
// Handshake bundle between current sources, the IF neuron scheduler and the next layer.
interface if_neuron_scheduler_if #(
  parameter int N_NEURONS = 4,
  parameter int W         = 16,
  parameter int IDXW      = $clog2(N_NEURONS)
);
  logic [N_NEURONS-1:0]   req;
  logic [N_NEURONS*W-1:0] cur;
  logic                   clr;
  logic [N_NEURONS-1:0]   gnt;
  logic                   ev_valid;
  logic                   ev_ready;
  logic [IDXW-1:0]        ev_idx;
  logic                   busy;

  modport master (
    output req, cur, clr, ev_ready,
    input  gnt, ev_valid, ev_idx, busy
  );

  modport slave (
    input  req, cur, clr, ev_ready,
    output gnt, ev_valid, ev_idx, busy
  );
endinterface

// File: rtl/if_neuron_scheduler.sv
// Integrate-and-fire engine: N neurons share one saturating adder/comparator,
// served round-robin; threshold crossings leave as valid/ready spike events.
module if_neuron_scheduler #(
  parameter int           N_NEURONS   = 4,
  parameter int           W           = 16,
  parameter logic [W-1:0] THRESHOLD   = 16'h8000,
  parameter logic [W-1:0] RESET_LEVEL = 16'h0000,
  parameter int           IDXW        = $clog2(N_NEURONS)
) (
  input logic                 clk,
  input logic                 rst,
  if_neuron_scheduler_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACC, EMIT} state_t;

  state_t               state, next_state;
  logic [IDXW-1:0]      rr_ptr;
  logic [IDXW-1:0]      win_idx;
  logic [IDXW-1:0]      cand;
  logic                 any_req;
  logic                 take;
  logic [N_NEURONS-1:0] gnt_next;
  logic [W-1:0]         cur_win;
  logic [IDXW-1:0]      idx_p0;
  logic [W-1:0]         cur_p0;
  logic [W-1:0]         sum_p0;
  logic                 fire_p0;
  logic [W-1:0]         mem [N_NEURONS];

  function automatic logic [W-1:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[W] ? {W{1'b1}} : s[W-1:0];
  endfunction

  // Round-robin scan starting just after the last winner.
  always_comb begin
    win_idx  = '0;
    cand     = '0;
    any_req  = 1'b0;
    gnt_next = '0;
    for (int k = 1; k <= N_NEURONS; k++) begin
      cand = IDXW'((int'(rr_ptr) + k) % N_NEURONS);
      if (!any_req && bus.req[cand]) begin
        any_req = 1'b1;
        win_idx = cand;
      end
    end
    gnt_next[win_idx] = 1'b1;
    cur_win = bus.cur[int'(win_idx)*W +: W];
    take    = (state == IDLE) && !bus.clr && any_req;
  end

  always_comb begin
    sum_p0  = sat_add(mem[idx_p0], cur_p0);
    fire_p0 = (sum_p0 >= THRESHOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    bus.busy   = (state != IDLE);
    case (state)
      IDLE:    if (take) next_state = ACC;
      ACC:     next_state = fire_p0 ? EMIT : IDLE;
      EMIT:    if (bus.ev_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Stage p0: latch the winning request for the single-cycle ACC update.
  always_ff @(posedge clk) begin
    if (take) begin
      idx_p0 <= win_idx;
      cur_p0 <= cur_win;
    end
  end

  // Writeback, arbitration pointer and event register; a clr lands last so it overrides writeback.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr       <= IDXW'(N_NEURONS - 1);
      bus.gnt      <= '0;
      bus.ev_valid <= 1'b0;
      bus.ev_idx   <= '0;
      for (int i = 0; i < N_NEURONS; i++) mem[i] <= RESET_LEVEL;
    end else begin
      bus.gnt <= take ? gnt_next : '0;
      if (take) rr_ptr <= win_idx;
      if (state == ACC) begin
        mem[idx_p0] <= fire_p0 ? RESET_LEVEL : sum_p0;
        if (fire_p0) begin
          bus.ev_valid <= 1'b1;
          bus.ev_idx   <= idx_p0;
        end
      end
      if (state == EMIT && bus.ev_ready) bus.ev_valid <= 1'b0;
      if (bus.clr) begin
        for (int i = 0; i < N_NEURONS; i++) mem[i] <= RESET_LEVEL;
      end
    end
  end

endmodule

// File: tb/tb_if_neuron_scheduler.sv
// Directed and randomized checks of the IF neuron scheduler against a transaction-level model.
module tb_if_neuron_scheduler;
  localparam int N = 4;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  if_neuron_scheduler_if #(.N_NEURONS(N), .W(W)) bus();

  if_neuron_scheduler #(
    .N_NEURONS(N), .W(W), .THRESHOLD(16'h8000), .RESET_LEVEL(16'h0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total  = 0;
  int passed = 0;
  int failed = 0;

  int         mem_m [N];
  int         last_m;
  logic [W-1:0] cur_v [N];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) mem_m[i] = 0;
  endtask

  task automatic model_reset();
    model_clear();
    last_m = N - 1;
  endtask

  function automatic int rr_pick(input logic [N-1:0] m, input int last);
    for (int k = 1; k <= N; k++)
      if (m[(last + k) % N]) return (last + k) % N;
    return 0;
  endfunction

  // Integrate one update in the model; returns whether it fires.
  function automatic bit model_update(input int i);
    int s;
    s = mem_m[i] + int'(cur_v[i]);
    if (s > 65535) s = 65535;
    last_m = i;
    if (s >= 32768) begin
      mem_m[i] = 0;
      return 1'b1;
    end
    mem_m[i] = s;
    return 1'b0;
  endfunction

  task automatic drive_cur();
    for (int i = 0; i < N; i++) bus.cur[i*W +: W] = cur_v[i];
  endtask

  // Each requester in mask is served once, in round-robin order.
  task automatic serve(input logic [N-1:0] mask, input int stall);
    logic [N-1:0] pend;
    int exp_i;
    int n;
    bit fire;
    pend = mask;
    drive_cur();
    bus.req = pend;
    while (pend != '0) begin
      exp_i = rr_pick(pend, last_m);
      n = 0;
      do begin
        tick();
        n++;
      end while (bus.gnt == '0 && n < 6);
      chk("gnt_latency", n, 1);
      chk("gnt", {28'd0, bus.gnt}, 32'(1) << exp_i);
      chk("busy_acc", {31'd0, bus.busy}, 1);
      if (bus.gnt == '0) begin
        bus.req = '0;
        return;
      end
      pend[exp_i] = 1'b0;
      bus.req = pend;
      fire = model_update(exp_i);
      tick();
      chk("ev_valid", {31'd0, bus.ev_valid}, {31'd0, fire});
      if (fire) begin
        chk("ev_idx", {30'd0, bus.ev_idx}, exp_i);
        if (stall > 0) begin
          bus.ev_ready = 1'b0;
          repeat (stall) begin
            tick();
            chk("stall_valid", {31'd0, bus.ev_valid}, 1);
            chk("stall_idx", {30'd0, bus.ev_idx}, exp_i);
            chk("stall_gnt", {28'd0, bus.gnt}, 0);
          end
          bus.ev_ready = 1'b1;
        end
        tick();
        chk("ev_drop", {31'd0, bus.ev_valid}, 0);
        chk("idle_after_ev", {31'd0, bus.busy}, 0);
      end else begin
        chk("idle_after_acc", {31'd0, bus.busy}, 0);
      end
    end
    bus.req = '0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [N-1:0] mask;
    bus.req = '0;
    bus.cur = '0;
    bus.clr = 1'b0;
    bus.ev_ready = 1'b1;
    for (int i = 0; i < N; i++) cur_v[i] = '0;
    rst = 1'b1;

    // T1 reset
    repeat (2) tick();
    rst = 1'b0;
    model_reset();
    chk("rst_gnt", {28'd0, bus.gnt}, 0);
    chk("rst_ev_valid", {31'd0, bus.ev_valid}, 0);
    chk("rst_ev_idx", {30'd0, bus.ev_idx}, 0);
    chk("rst_busy", {31'd0, bus.busy}, 0);

    // T2 accumulate on neuron 0
    cur_v[0] = 16'h4000; serve(4'b0001, 0);
    serve(4'b0001, 0);
    cur_v[0] = 16'h7FFF; serve(4'b0001, 0);
    cur_v[0] = 16'h0000; serve(4'b0001, 0);
    cur_v[0] = 16'h0001; serve(4'b0001, 0);

    // T3 round robin with all requesters held and re-raised
    rst = 1'b1; tick(); rst = 1'b0; model_reset();
    for (int i = 0; i < N; i++) cur_v[i] = 16'h0001;
    drive_cur();
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      do begin
        tick();
        n++;
      end while (bus.gnt == '0 && n < 6);
      chk("rr_order", {28'd0, bus.gnt}, 32'(1) << (k % N));
      void'(model_update(k % N));
      bus.req[k % N] = 1'b0;
      tick();
      chk("rr_no_ev", {31'd0, bus.ev_valid}, 0);
      bus.req[k % N] = 1'b1;
    end
    bus.req = '0;
    tick();

    // T4 saturation on neuron 2
    cur_v[2] = 16'h0001; serve(4'b0100, 0);
    cur_v[2] = 16'hFFFF; serve(4'b0100, 0);

    // T5 backpressure: neuron 1 fires while neuron 3 waits
    cur_v[0] = 16'h0002; serve(4'b0001, 0);
    cur_v[1] = 16'h8000; cur_v[3] = 16'h0010;
    serve(4'b1010, 5);

    // T6 clr during ACC of a firing update
    cur_v[0] = 16'h0100; serve(4'b0001, 0);
    cur_v[1] = 16'h8000; drive_cur();
    bus.req = 4'b0010;
    tick();
    chk("clr_acc_gnt", {28'd0, bus.gnt}, 2);
    bus.req = '0;
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    model_clear(); last_m = 1;
    chk("clr_acc_ev_valid", {31'd0, bus.ev_valid}, 1);
    chk("clr_acc_ev_idx", {30'd0, bus.ev_idx}, 1);
    tick();
    chk("clr_acc_ev_drop", {31'd0, bus.ev_valid}, 0);
    cur_v[0] = 16'h7F00; serve(4'b0001, 0);

    // clr in IDLE blocks the grant that cycle
    bus.clr = 1'b1; bus.req = 4'b0100;
    tick();
    chk("clr_idle_no_gnt", {28'd0, bus.gnt}, 0);
    chk("clr_idle_busy", {31'd0, bus.busy}, 0);
    bus.clr = 1'b0; bus.req = '0;
    model_clear();

    // clr in EMIT keeps the pending event
    cur_v[3] = 16'hFFFF; drive_cur();
    bus.req = 4'b1000;
    tick();
    bus.req = '0; bus.ev_ready = 1'b0;
    void'(model_update(3));
    tick();
    chk("clr_emit_pre", {31'd0, bus.ev_valid}, 1);
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    model_clear();
    chk("clr_emit_valid", {31'd0, bus.ev_valid}, 1);
    chk("clr_emit_idx", {30'd0, bus.ev_idx}, 3);
    bus.ev_ready = 1'b1;
    tick();
    chk("clr_emit_drop", {31'd0, bus.ev_valid}, 0);

    // rst during EMIT drops the event
    cur_v[2] = 16'hFFFF; drive_cur();
    bus.req = 4'b0100;
    tick();
    bus.req = '0; bus.ev_ready = 1'b0;
    tick();
    chk("rst_emit_pre", {31'd0, bus.ev_valid}, 1);
    rst = 1'b1;
    tick();
    chk("rst_emit_valid", {31'd0, bus.ev_valid}, 0);
    chk("rst_emit_busy", {31'd0, bus.busy}, 0);
    rst = 1'b0; bus.ev_ready = 1'b1;
    model_reset();

    // Randomized traffic
    repeat (40) begin
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 4))
          0:       cur_v[i] = 16'h0000;
          1:       cur_v[i] = 16'hFFFF;
          2:       cur_v[i] = 16'(16'h7000 + $urandom_range(0, 16'h2000));
          default: cur_v[i] = 16'($urandom_range(0, 16'h3FFF));
        endcase
      end
      mask = 4'($urandom_range(1, 15));
      serve(mask, $urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) begin
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        model_clear();
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
